// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bit-field access blocks.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_BF_READ,
    RGGEN_BF_WRITE,
    RGGEN_BF_PULSE,
    RGGEN_BF_RMW
  } rggen_bf_op;

endpackage

// File: rtl/rggen_bit_field_if.sv
// Single bit-field access port: one read or write strobe per cycle plus data/mask.
interface rggen_bit_field_if #(
  parameter int unsigned WIDTH = 32
);
  logic             read_access;
  logic             write_access;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] read_data;

  modport master (
    output read_access, write_access, write_data, write_mask,
    input  read_data
  );

  modport slave (
    input  read_access, write_access, write_data, write_mask,
    output read_data
  );
endinterface

// File: rtl/rggen_bit_field_initiator.sv
// Initiator end of rggen_bit_field_if: turns host requests into single bit-field accesses.
// Define RGGEN_BIT_FIELD_INITIATOR_RMW_EN to enable read-modify-write; otherwise RMW errors.
module rggen_bit_field_initiator
  import rggen_rtl_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter logic        SET_CLEAR_VALUE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  rggen_bf_op        i_req_op,
  input  logic [WIDTH-1:0]  i_req_data,
  input  logic [WIDTH-1:0]  i_req_mask,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [WIDTH-1:0]  o_resp_data,
  output logic              o_resp_error,
  rggen_bit_field_if.master bit_field_if
);

`ifdef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
  typedef enum logic [1:0] {StIdle, StAccess, StModify, StResponse} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccess, StResponse} state_e;
`endif

  state_e           state_q, state_d;
  rggen_bf_op       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_error_q, resp_error_d;
  logic             req_accept;

  assign req_accept   = (state_q == StIdle) && i_req_valid;
  assign o_req_ready  = (state_q == StIdle);
  assign o_resp_valid = (state_q == StResponse);
  assign o_resp_data  = resp_data_q;
  assign o_resp_error = resp_error_q;

`ifdef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
  logic [WIDTH-1:0] merged_data;
  // resp_data_q holds the value read during ACCESS while in MODIFY.
  assign merged_data = (resp_data_q & ~mask_q) | (data_q & mask_q);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q         <= RGGEN_BF_READ;
      data_q       <= '0;
      mask_q       <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      if (req_accept) begin
        op_q   <= i_req_op;
        data_q <= i_req_data;
        mask_q <= i_req_mask;
      end
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  always_comb begin
    state_d                   = state_q;
    resp_data_d               = resp_data_q;
    resp_error_d              = resp_error_q;
    bit_field_if.read_access  = 1'b0;
    bit_field_if.write_access = 1'b0;
    bit_field_if.write_data   = '0;
    bit_field_if.write_mask   = '0;

    case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          resp_data_d  = '0;
          resp_error_d = 1'b0;
          state_d      = StAccess;
`ifndef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
          if (i_req_op == RGGEN_BF_RMW) begin
            resp_error_d = 1'b1;
            state_d      = StResponse;
          end
`endif
        end
      end
      StAccess: begin
        state_d = StResponse;
        case (op_q)
          RGGEN_BF_READ: begin
            bit_field_if.read_access = 1'b1;
            resp_data_d              = bit_field_if.read_data;
          end
          RGGEN_BF_WRITE: begin
            bit_field_if.write_access = 1'b1;
            bit_field_if.write_data   = data_q;
            bit_field_if.write_mask   = mask_q;
            resp_data_d               = data_q & mask_q;
          end
          RGGEN_BF_PULSE: begin
            // Every enabled bit carries the field's active level.
            bit_field_if.write_access = 1'b1;
            bit_field_if.write_data   = SET_CLEAR_VALUE ? mask_q : ~mask_q;
            bit_field_if.write_mask   = mask_q;
            resp_data_d               = mask_q;
          end
          default: begin
`ifdef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
            bit_field_if.read_access = 1'b1;
            resp_data_d              = bit_field_if.read_data;
            state_d                  = StModify;
`endif
          end
        endcase
      end
`ifdef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
      StModify: begin
        bit_field_if.write_access = 1'b1;
        bit_field_if.write_data   = merged_data;
        bit_field_if.write_mask   = '1;
        resp_data_d               = merged_data;
        state_d                   = StResponse;
      end
`endif
      StResponse: begin
        if (i_resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_rggen_bit_field_initiator.sv
// Self-checking bench: two initiators (write-one and write-zero pulse polarity) vs. a timeline model.
module tb_rggen_bit_field_initiator;
  import rggen_rtl_pkg::*;

`ifdef RGGEN_BIT_FIELD_INITIATOR_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  rggen_bf_op req_op = RGGEN_BF_READ;
  logic [7:0] req_data = '0;
  logic [7:0] req_mask = '0;
  logic       resp_ready = 1'b0;
  logic [1:0] req_ready;
  logic [1:0] resp_valid;
  logic [1:0] resp_error;
  logic [7:0] resp_data [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rggen_bit_field_if #(.WIDTH(8)) bf0 ();
  rggen_bit_field_if #(.WIDTH(8)) bf1 ();

  rggen_bit_field_initiator #(.WIDTH(8), .SET_CLEAR_VALUE(1'b1)) dut (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
    .i_req_op(req_op), .i_req_data(req_data), .i_req_mask(req_mask),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready), .o_resp_data(resp_data[0]),
    .o_resp_error(resp_error[0]), .bit_field_if(bf0)
  );

  rggen_bit_field_initiator #(.WIDTH(8), .SET_CLEAR_VALUE(1'b0)) dut_wzc (
    .clk(clk), .rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
    .i_req_op(req_op), .i_req_data(req_data), .i_req_mask(req_mask),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready), .o_resp_data(resp_data[1]),
    .o_resp_error(resp_error[1]), .bit_field_if(bf1)
  );

  // Slave fields: plain RW, or clear-on-active-level when w1c is set.
  logic [7:0] field [2];
  logic       w1c = 1'b0;
  logic       load_en = 1'b0;
  logic [7:0] load_val = '0;
  logic [1:0] b_rd, b_wr;
  logic [7:0] b_wd [2];
  logic [7:0] b_wm [2];

  assign b_rd[0] = bf0.read_access;
  assign b_rd[1] = bf1.read_access;
  assign b_wr[0] = bf0.write_access;
  assign b_wr[1] = bf1.write_access;
  assign b_wd[0] = bf0.write_data;
  assign b_wd[1] = bf1.write_data;
  assign b_wm[0] = bf0.write_mask;
  assign b_wm[1] = bf1.write_mask;
  assign bf0.read_data = field[0];
  assign bf1.read_data = field[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (load_en) field[k] <= load_val;
      else if (b_wr[k]) begin
        if (!w1c) field[k] <= (field[k] & ~b_wm[k]) | (b_wd[k] & b_wm[k]);
        else if (k == 0) field[k] <= field[k] & ~(b_wd[k] & b_wm[k]);
        else field[k] <= field[k] & ~(~b_wd[k] & b_wm[k]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a transaction's age counts cycles since acceptance; the first nbus ages are
  // bus cycles, after which the response is offered until accepted.
  logic       m_active;
  int         m_age;
  rggen_bf_op m_op;
  logic [7:0] m_data, m_mask;
  logic [7:0] m_rdcap [2];

  function automatic int nbus(input rggen_bf_op op);
    if (op == RGGEN_BF_RMW) return RMW_EN ? 2 : 0;
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_age    <= 0;
    end else if (!m_active) begin
      if (req_valid) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_op     <= req_op;
        m_data   <= req_data;
        m_mask   <= req_mask;
      end
    end else begin
      if (m_age == 1 && (m_op == RGGEN_BF_READ || (m_op == RGGEN_BF_RMW && RMW_EN)))
        for (int k = 0; k < 2; k++) m_rdcap[k] <= field[k];
      if (m_age > nbus(m_op)) begin
        if (resp_ready) m_active <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic       resp_ph, e_rd, e_wr, e_err;
    logic [7:0] e_wd, e_wm, e_rdata, merged;
    resp_ph = m_active && (m_age > nbus(m_op));
    e_rd = m_active && !resp_ph && (m_age == 1) &&
           (m_op == RGGEN_BF_READ || m_op == RGGEN_BF_RMW);
    e_wr = m_active && !resp_ph && !e_rd;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d req_ready", k), req_ready[k], !m_active);
      chk($sformatf("u%0d resp_valid", k), resp_valid[k], resp_ph);
      chk($sformatf("u%0d read_access", k), b_rd[k], e_rd);
      chk($sformatf("u%0d write_access", k), b_wr[k], e_wr);
      merged = (m_rdcap[k] & ~m_mask) | (m_data & m_mask);
      if (e_wr) begin
        case (m_op)
          RGGEN_BF_WRITE: begin e_wd = m_data; e_wm = m_mask; end
          RGGEN_BF_PULSE: begin e_wd = (k == 0) ? m_mask : ~m_mask; e_wm = m_mask; end
          default:        begin e_wd = merged; e_wm = 8'hFF; end
        endcase
        chk($sformatf("u%0d write_data", k), b_wd[k], e_wd);
        chk($sformatf("u%0d write_mask", k), b_wm[k], e_wm);
      end
      if (resp_ph) begin
        case (m_op)
          RGGEN_BF_READ:  e_rdata = m_rdcap[k];
          RGGEN_BF_WRITE: e_rdata = m_data & m_mask;
          RGGEN_BF_PULSE: e_rdata = m_mask;
          default:        e_rdata = RMW_EN ? merged : 8'h00;
        endcase
        e_err = (m_op == RGGEN_BF_RMW) && !RMW_EN;
        chk($sformatf("u%0d resp_data", k), resp_data[k], e_rdata);
        chk($sformatf("u%0d resp_error", k), resp_error[k], e_err);
      end
    end
  end

  int         t_lat, t_nrd, t_nwr;
  logic [7:0] t_wd0, t_wd1, t_wm0, t_rdat0, t_rdat1;
  logic       t_err;

  task automatic load(input logic [7:0] v);
    @(posedge clk); #1 load_en = 1'b1; load_val = v;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  // Returns one step after the accepting edge, i.e. inside cycle N+1.
  task automatic send(input rggen_bf_op op, input logic [7:0] d, input logic [7:0] m);
    int guard;
    req_valid = 1'b1; req_op = op; req_data = d; req_mask = m;
    guard = 0;
    @(negedge clk);
    while (!req_ready[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready[0]) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    logic got;
    got = 1'b0; t_lat = 0; t_nrd = 0; t_nwr = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (b_rd[0]) t_nrd++;
      if (b_wr[0]) begin
        t_nwr++; t_wd0 = b_wd[0]; t_wd1 = b_wd[1]; t_wm0 = b_wm[0];
      end
      if (resp_valid[0]) begin
        got = 1'b1; t_lat = c;
        t_rdat0 = resp_data[0]; t_rdat1 = resp_data[1]; t_err = resp_error[0];
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  task automatic ack();
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset req_ready", req_ready[0], 1);
    chk("reset resp_valid", resp_valid[0], 0);
    chk("reset resp_data", resp_data[0], 0);
    chk("reset resp_error", resp_error[0], 0);
    chk("reset strobes", {b_rd[0], b_wr[0]}, 0);
    @(negedge clk) rst = 1'b0;

    load(8'hA5);
    send(RGGEN_BF_READ, 8'h00, 8'hFF); wait_resp();
    chk("read latency", t_lat, 2);
    chk("read strobes", {t_nrd[7:0], t_nwr[7:0]}, 16'h0100);
    chk("read data", t_rdat0, 8'hA5);
    chk("read error", t_err, 0);
    ack();

    send(RGGEN_BF_WRITE, 8'h3C, 8'h0F); wait_resp();
    chk("write latency", t_lat, 2);
    chk("write strobes", {t_nrd[7:0], t_nwr[7:0]}, 16'h0001);
    chk("write wdata", t_wd0, 8'h3C);
    chk("write wmask", t_wm0, 8'h0F);
    chk("write resp", t_rdat0, 8'h0C);
    ack();

    load(8'hFF); w1c = 1'b1;
    send(RGGEN_BF_PULSE, 8'h00, 8'h81); wait_resp();
    chk("pulse wdata scv1", t_wd0, 8'h81);
    chk("pulse wdata scv0", t_wd1, 8'h7E);
    chk("pulse resp", t_rdat0, 8'h81);
    ack(); w1c = 1'b0;
    send(RGGEN_BF_READ, 8'h00, 8'hFF); wait_resp();
    chk("pulse readback scv1", t_rdat0, 8'h7E);
    chk("pulse readback scv0", t_rdat1, 8'h7E);
    ack();

    load(8'hF0);
    send(RGGEN_BF_RMW, 8'h0A, 8'h0F); wait_resp();
    if (RMW_EN) begin
      chk("rmw latency", t_lat, 3);
      chk("rmw strobes", {t_nrd[7:0], t_nwr[7:0]}, 16'h0101);
      chk("rmw wdata", t_wd0, 8'hFA);
      chk("rmw resp", t_rdat0, 8'hFA);
      chk("rmw error", t_err, 0);
    end else begin
      chk("rmw latency", t_lat, 1);
      chk("rmw strobes", {t_nrd[7:0], t_nwr[7:0]}, 16'h0000);
      chk("rmw resp", t_rdat0, 8'h00);
      chk("rmw error", t_err, 1);
    end
    ack();

    load(8'h5A);
    send(RGGEN_BF_WRITE, 8'hFF, 8'h00); wait_resp();
    chk("empty mask strobes", {t_nrd[7:0], t_nwr[7:0]}, 16'h0001);
    ack();
    send(RGGEN_BF_READ, 8'h00, 8'hFF); wait_resp();
    chk("empty mask field", t_rdat0, 8'h5A);
    ack();

    // Backpressure with a competing request held pending.
    load(8'h00);
    send(RGGEN_BF_WRITE, 8'h3C, 8'h0F); wait_resp();
    req_valid = 1'b1; req_op = RGGEN_BF_READ; req_data = 8'h00; req_mask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp req_ready", req_ready[0], 0);
      chk("bp resp_data", resp_data[0], 8'h0C);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    @(posedge clk); #1 resp_ready = 1'b0;
    @(negedge clk);
    chk("bp ready after ack", req_ready[0], 1);
    @(posedge clk); #1 req_valid = 1'b0;
    wait_resp();
    chk("bp next latency", t_lat, 2);
    chk("bp next data", t_rdat0, 8'h0C);
    ack();

    // Reset during the ACCESS cycle of a write.
    load(8'h11);
    send(RGGEN_BF_WRITE, 8'hEE, 8'hFF);
    chk("rst pre write_access", b_wr[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("rst write_access drop", b_wr, 2'b00);
    chk("rst req_ready", req_ready[0], 1);
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst no response", resp_valid[0], 0);
    end
    chk("rst field untouched", field[0], 8'h11);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (i == 1000) begin
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end
      req_valid  = ($urandom_range(0, 1) == 1);
      req_op     = rggen_bf_op'(2'($urandom_range(0, 3)));
      req_data   = 8'($urandom);
      req_mask   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 req_valid = 1'b0; resp_ready = 1'b1;
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
